// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//
// Purpose:
//    Definitions shared by the memory copy engine and the single-port RAM it
//    drives: the engine's state encoding, the command mode constants, and the
//    default data/address widths the RAM is built with.
//
// Contents:
//    MEM_DWIDTH  default data word width
//    MEM_AWIDTH  default address width (RAM depth is 2**MEM_AWIDTH)
//    MODE_COPY   command mode: copy src block to dst block
//    MODE_FILL   command mode: fill dst block with a constant word
//    state_e     engine sequencer states
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_DWIDTH = 16;
    localparam int MEM_AWIDTH = 12;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // IDLE waits for a command, READ presents the source address, WRITE
    // stores one word at the destination, FIN emits the completion pulse.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Purpose:
//    Block-move initiator for a single-port synchronous RAM with a one-cycle
//    registered read port. Accepts a copy or fill command, walks the RAM port
//    one word at a time in ascending address order, and reports completion
//    together with a running checksum of every word written.
//
// Ports:
//    clk        clock, all state changes on the rising edge
//    rst        synchronous active-high reset
//    start      command strobe, only looked at while idle
//    mode       0 = copy, 1 = fill
//    src        copy source base address
//    dst        destination base address
//    len        word count, values above 2**AWIDTH are treated as 2**AWIDTH
//    fill_data  word written by a fill command
//    busy       command in progress
//    done       one-cycle completion pulse
//    checksum   sum of written words modulo 2**DWIDTH
//    mem_load   RAM write enable
//    mem_addr   RAM address
//    mem_d      RAM write data
//    mem_q      RAM read data, valid the cycle after its address
// -----------------------------------------------------------------------------
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int DWIDTH = MEM_DWIDTH,
    parameter int AWIDTH = MEM_AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [AWIDTH-1:0] src,
    input  logic [AWIDTH-1:0] dst,
    input  logic [AWIDTH:0]   len,
    input  logic [DWIDTH-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] checksum,
    output logic              mem_load,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_d,
    input  logic [DWIDTH-1:0] mem_q
);

    localparam logic [AWIDTH:0] LEN_MAX = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] LEN_ONE = {{AWIDTH{1'b0}}, 1'b1};

    state_e              state_q;
    logic [AWIDTH-1:0]   srcPtr_q;
    logic [AWIDTH-1:0]   dstPtr_q;
    logic [AWIDTH:0]     count_q;
    logic                mode_q;
    logic [DWIDTH-1:0]   fillWord_q;
    logic [DWIDTH-1:0]   checksum_q;
    logic                busy_q;
    logic                done_q;

    logic [AWIDTH:0]     lenClamped_d;
    logic [DWIDTH-1:0]   checksum_d;
    logic [DWIDTH-1:0]   memD;
    logic [AWIDTH-1:0]   memAddr;
    logic                memLoad;

    // Any count with the top bit set is already at least 2**AWIDTH, so the
    // clamp only needs that bit: it saturates to exactly one full memory.
    assign lenClamped_d = len[AWIDTH] ? LEN_MAX : len;

    // RAM-side decode. Everything here depends on registered state only,
    // except the copy data which must pass mem_q straight through because the
    // RAM delivers the source word in the very cycle it is written back.
    always_comb begin
        memLoad = 1'b0;
        memAddr = '0;
        memD    = '0;
        case (state_q)
            READ: begin
                memAddr = srcPtr_q;
            end
            WRITE: begin
                memLoad = 1'b1;
                memAddr = dstPtr_q;
                memD    = (mode_q == MODE_FILL) ? fillWord_q : mem_q;
            end
            default: begin
                memLoad = 1'b0;
            end
        endcase
    end

    assign checksum_d = checksum_q + memD;

    // Sequencer. Copy alternates READ/WRITE so each word sees the RAM's one
    // cycle read latency; fill stays in WRITE and stores a word per cycle.
    // busy/done are computed from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            srcPtr_q   <= '0;
            dstPtr_q   <= '0;
            count_q    <= '0;
            mode_q     <= MODE_COPY;
            fillWord_q <= '0;
            checksum_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        srcPtr_q   <= src;
                        dstPtr_q   <= dst;
                        count_q    <= lenClamped_d;
                        mode_q     <= mode;
                        fillWord_q <= fill_data;
                        checksum_q <= '0;
                        if (lenClamped_d == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= (mode == MODE_FILL) ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    state_q <= WRITE;
                end
                WRITE: begin
                    checksum_q <= checksum_d;
                    srcPtr_q   <= srcPtr_q + 1'b1;
                    dstPtr_q   <= dstPtr_q + 1'b1;
                    count_q    <= count_q - LEN_ONE;
                    if (count_q == LEN_ONE) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= (mode_q == MODE_FILL) ? WRITE : READ;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign checksum = checksum_q;
    assign mem_load = memLoad;
    assign mem_addr = memAddr;
    assign mem_d    = memD;

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
//
// Purpose:
//    Self-checking bench for mem_copy_engine. Runs the engine against a
//    behavioural single-port RAM (registered read, read-old-data on write,
//    initialised with mem[i] = i) and compares every command against a word
//    level reference model: expected write sequence and timing, busy/done
//    timing, checksum and the resulting memory image.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic          clk;
    logic          rst;
    logic          start;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] fill_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
    logic          mem_load;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;

    logic [DW-1:0] ram    [0:DEPTH-1];
    logic [DW-1:0] refMem [0:DEPTH-1];
    logic          initRam;

    int errorCount = 0;
    int checkCount = 0;

    mem_copy_engine #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .fill_data (fill_data),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .mem_load  (mem_load),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
        .mem_q     (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read that returns the old word on a write.
    always @(posedge clk) begin
        if (initRam) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(i);
        end else if (mem_load) begin
            ram[mem_addr] <= mem_d;
        end
        mem_q <= ram[mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int memDiff();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== refMem[i]) n++;
        return n;
    endfunction

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Issues one command at the next falling edge (cycle 0 = accept cycle) and
    // follows it to done. intrude > 0 raises start with junk arguments in that
    // cycle, which the engine must ignore.
    task automatic applyStimulus(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                                 input logic [AW:0] l, input logic [DW-1:0] f,
                                 input int intrude, input string name);
        int            n;
        int            c;
        int            doneAt;
        int            busyCnt;
        int            expDone;
        int            expBusy;
        int            badW;
        int            badT;
        logic [DW-1:0] sum;
        logic [DW-1:0] word;
        int            expAddr[$];
        logic [DW-1:0] expData[$];
        int            expCyc[$];
        int            obsAddr[$];
        logic [DW-1:0] obsData[$];
        int            obsCyc[$];

        n   = (int'(l) > DEPTH) ? DEPTH : int'(l);
        sum = '0;
        for (int i = 0; i < n; i++) begin
            word = m ? f : refMem[(int'(s) + i) % DEPTH];
            refMem[(int'(d) + i) % DEPTH] = word;
            sum += word;
            expAddr.push_back((int'(d) + i) % DEPTH);
            expData.push_back(word);
            expCyc.push_back(m ? i + 1 : 2 * (i + 1));
        end
        expDone = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
        expBusy = m ? n : 2 * n;

        @(negedge clk);
        start = 1'b1; mode = m; src = s; dst = d; len = l; fill_data = f;
        c = 0; doneAt = 0; busyCnt = 0;
        while (doneAt == 0 && c < expDone + 20) begin
            @(negedge clk);
            c++;
            if (busy) busyCnt++;
            if (mem_load) begin
                obsAddr.push_back(int'(mem_addr));
                obsData.push_back(mem_d);
                obsCyc.push_back(c);
            end
            if (done) doneAt = c;
            start = (c == intrude);
            if (c == intrude) begin
                mode = 1'($urandom); src = AW'($urandom); dst = AW'($urandom);
                len = (AW + 1)'($urandom_range(1, 30)); fill_data = DW'($urandom);
            end
        end

        badW = 0; badT = 0;
        for (int i = 0; i < obsAddr.size() && i < expAddr.size(); i++) begin
            if (obsAddr[i] != expAddr[i] || obsData[i] !== expData[i]) badW++;
            if (obsCyc[i] != expCyc[i]) badT++;
        end
        checkOutput({name, ".doneCycle"}, doneAt, expDone);
        checkOutput({name, ".busyCycles"}, busyCnt, expBusy);
        checkOutput({name, ".writeCount"}, obsAddr.size(), n);
        checkOutput({name, ".writeData"}, badW, 0);
        checkOutput({name, ".writeTiming"}, badT, 0);
        checkOutput({name, ".checksum"}, checksum, sum);
        checkOutput({name, ".memImage"}, memDiff(), 0);
    endtask

    initial begin
        int loads;
        int doneSeen;

        for (int i = 0; i < DEPTH; i++) refMem[i] = DW'(i);
        initRam = 1'b1;
        rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_data = '0;
        repeat (3) @(negedge clk);
        initRam = 1'b0;

        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.checksum", checksum, 0);
        checkOutput("reset.memLoad", mem_load, 0);
        checkOutput("reset.memAddr", mem_addr, 0);
        checkOutput("reset.memD", mem_d, 0);
        rst = 1'b0;
        idle(1);

        applyStimulus(1'b0, 12'h010, 12'h100, 13'd4, 16'h0000, 0, "copy4");
        checkOutput("copy4.sumConst", checksum, 32'h0046);
        checkOutput("copy4.word3", ram[12'h103], 32'h0013);
        idle(2);
        checkOutput("copy4.sumHold", checksum, 32'h0046);

        applyStimulus(1'b1, 12'h000, 12'hFFE, 13'd4, 16'hA5A5, 0, "fillWrap");
        checkOutput("fillWrap.sumConst", checksum, 32'h9694);
        checkOutput("fillWrap.word001", ram[12'h001], 32'hA5A5);

        applyStimulus(1'b0, 12'h005, 12'h006, 13'd0, 16'h0000, 0, "len0");
        checkOutput("len0.sumConst", checksum, 32'h0000);

        applyStimulus(1'b0, 12'h020, 12'h021, 13'd3, 16'h0000, 0, "overlap");
        checkOutput("overlap.sumConst", checksum, 32'h0060);
        checkOutput("overlap.word023", ram[12'h023], 32'h0020);

        // Reset in the cycle after the third write of an eight word copy.
        idle(1);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src = 12'h200; dst = 12'h300; len = 13'd8;
        loads = 0; doneSeen = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_load) loads++;
            if (done) doneSeen++;
            if (c == 8) begin
                checkOutput("abort.busy", busy, 0);
                checkOutput("abort.checksum", checksum, 0);
                checkOutput("abort.memLoad", mem_load, 0);
            end
            rst = (c == 7);
        end
        for (int i = 0; i < 3; i++) refMem[12'h300 + i] = refMem[12'h200 + i];
        checkOutput("abort.writes", loads, 3);
        checkOutput("abort.noDone", doneSeen, 0);
        checkOutput("abort.memImage", memDiff(), 0);

        // Start during busy and during FIN is ignored; start right after done is taken.
        applyStimulus(1'b0, 12'h040, 12'h400, 13'd6, 16'h0000, 3, "intrudeBusy");
        applyStimulus(1'b1, 12'h000, 12'h500, 13'd3, 16'h1234, 4, "intrudeFin");
        applyStimulus(1'b0, 12'h500, 12'h600, 13'd3, 16'h0000, 0, "backToBack");

        applyStimulus(1'b1, 12'h000, 12'h800, 13'h1FFF, 16'h0F0F, 0, "fillClamp");

        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'($urandom), AW'($urandom), AW'($urandom),
                          (AW + 1)'($urandom_range(0, 20)), DW'($urandom),
                          int'($urandom_range(0, 5)), $sformatf("rand%0d", k));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
